simple_assign_checker: RTL and testbench

- Self-checking stimulus/response engine for the `simple_assign`-style combinational logic block.
- Drives the five inputs (a..e) through all 32 combinations and samples the four outputs (out_and, out_or, out_not, out_complex).
- Compares each sample with an internally computed golden model and reports mismatch count, first failing vector and pass/fail.
- Sits on the opposite side of the same 5-in/4-out interface and is used as an in-fabric test harness.

---
 rtl/simple_assign_checker.sv | 195 +++++++++++++++++++
 tb/tb_simple_assign_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_assign_checker.sv
// ============================================================================
// simple_assign_checker
// ----------------------------------------------------------------------------
// Self-checking stimulus/response engine for a `simple_assign`-style
// combinational block (5 inputs a..e, 4 outputs). A sweep drives all 32
// input vectors, waits a configurable number of settle cycles per vector,
// compares the responses with a built-in golden model and reports the number
// of mismatching vectors, the first failing vector and an overall pass flag.
//
// Per-vector timing: DRIVE (1) + SETTLE (SETTLE_CYCLES) + CHECK (1) cycles,
// so `done` rises 32*(2+SETTLE_CYCLES) cycles after the edge sampling start.
//
// Parameters:
//   SETTLE_CYCLES  idle cycles between driving a vector and sampling (0..15)
//   ERR_W          width of the saturating mismatch counter
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous, active-high reset
//   start           begin a sweep; honoured only in IDLE or DONE
//   a..e            stimulus, {a,b,c,d,e} = current vector (a is bit 4)
//   out_and         response from the block under check
//   out_or          response from the block under check
//   out_not         response from the block under check
//   out_complex     response from the block under check
//   busy            sweep in progress (DRIVE/SETTLE/CHECK)
//   done            sweep finished; held until restart or reset
//   pass            valid with done; 1 when no mismatch was seen
//   err_count       mismatching vectors, saturating at 2^ERR_W-1
//   first_err_valid at least one mismatch seen in this sweep
//   first_err_vec   vector {a,b,c,d,e} of the first mismatch
//
// Build option:
//   SIMPLE_ASSIGN_CHK_STOP_ON_ERR_EN  when defined, the first mismatch ends
//                                     the sweep immediately (a..e keep the
//                                     failing vector). Default: full sweep.
// ============================================================================
module simple_assign_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             e,
    input  logic             out_and,
    input  logic             out_or,
    input  logic             out_not,
    input  logic             out_complex,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [4:0]       first_err_vec
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    // Reload value for the settle down-counter; only used when SETTLE_CYCLES>0.
    localparam logic [3:0] SETTLE_LAST =
        (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    localparam logic [4:0] LAST_VEC = 5'd31;

    state_t           state;
    logic [4:0]       vec;
    logic [3:0]       settle_cnt;

    logic [3:0]       exp_resp;
    logic [3:0]       got_resp;
    logic             mismatch;
    logic             sweep_end;
    logic [ERR_W-1:0] err_next;

    // ------------------------------------------------------------------------
    // Golden model and compare. The model is evaluated on the registered
    // stimulus, which is exactly what the block under check is seeing.
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        exp_resp = 4'b0000;
        exp_resp[3] = a & b & c;                 // and
        exp_resp[2] = a | b | c | d;             // or
        exp_resp[1] = ~(a & b);                  // not
        exp_resp[0] = (a & b) | (c & d & e);     // complex

        got_resp = {out_and, out_or, out_not, out_complex};
        mismatch = (got_resp != exp_resp);

        // Saturating increment: holds at all-ones.
        err_next = (&err_count) ? err_count : err_count + ERR_W'(1);

`ifdef SIMPLE_ASSIGN_CHK_STOP_ON_ERR_EN
        sweep_end = mismatch || (vec == LAST_VEC);
`else
        sweep_end = (vec == LAST_VEC);
`endif
    end

    // ------------------------------------------------------------------------
    // Sweep FSM with registered outputs.
    // ------------------------------------------------------------------------
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            vec             <= 5'd0;
            settle_cnt      <= 4'd0;
            {a, b, c, d, e} <= 5'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 5'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Clear previous results and launch vector 0.
                        vec             <= 5'd0;
                        {a, b, c, d, e} <= 5'd0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= 5'd0;
                        state           <= DRIVE;
                    end
                end

                DRIVE: begin
                    if (SETTLE_CYCLES > 0) begin
                        settle_cnt <= SETTLE_LAST;
                        state      <= SETTLE;
                    end else begin
                        state <= CHECK;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= vec;
                        end
                    end

                    if (sweep_end) begin
                        // Stimulus is left on the last (or failing) vector.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Count is zero afterwards only if it was zero before
                        // and this vector matched.
                        pass  <= !mismatch && (err_count == '0);
                        state <= DONE;
                    end else begin
                        vec             <= vec + 5'd1;
                        {a, b, c, d, e} <= vec + 5'd1;
                        state           <= DRIVE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_assign_checker.sv
// ============================================================================
// tb_simple_assign_checker
// ----------------------------------------------------------------------------
// Bench for simple_assign_checker. Two instances:
//   dut  : defaults (SETTLE_CYCLES=1, ERR_W=6), responses from a golden
//          model with a selectable fault (mode).
//   dut4 : SETTLE_CYCLES=0, ERR_W=4, out_and always inverted.
// Expected results come from a hand-filled table, with separate columns for
// builds with SIMPLE_ASSIGN_CHK_STOP_ON_ERR_EN defined.
// ============================================================================
module tb_simple_assign_checker;

    localparam int BUDGET = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start4;
    int         mode;

    // dut signals
    logic       a, b, c, d, e;
    logic       out_and, out_or, out_not, out_complex;
    logic       busy, done, pass;
    logic [5:0] err_count;
    logic       first_err_valid;
    logic [4:0] first_err_vec;

    // dut4 signals
    logic       a4, b4, c4, d4, e4;
    logic       out_and4, out_or4, out_not4, out_complex4;
    logic       busy4, done4, pass4;
    logic [3:0] err_count4;
    logic       first_err_valid4;
    logic [4:0] first_err_vec4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    simple_assign_checker dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .c(c), .d(d), .e(e),
        .out_and(out_and), .out_or(out_or), .out_not(out_not),
        .out_complex(out_complex),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
    );

    simple_assign_checker #(.SETTLE_CYCLES(0), .ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .a(a4), .b(b4), .c(c4), .d(d4), .e(e4),
        .out_and(out_and4), .out_or(out_or4), .out_not(out_not4),
        .out_complex(out_complex4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err_count4),
        .first_err_valid(first_err_valid4), .first_err_vec(first_err_vec4)
    );

    // Reference simple_assign block: {and, or, not, complex}.
    function automatic logic [3:0] ref_block(input logic [4:0] v);
        logic ia, ib, ic, id, ie;
        {ia, ib, ic, id, ie} = v;
        return {ia & ib & ic, ia | ib | ic | id, ~(ia & ib),
                (ia & ib) | (ic & id & ie)};
    endfunction

    // Block under check with a selectable fault:
    // 0 golden, 1 out_not stuck 0, 2 out_and inverted,
    // 3 out_complex stuck 0, 4 out_or stuck 0.
    logic [3:0] resp, resp4;
    always_comb begin
        resp = ref_block({a, b, c, d, e});
        case (mode)
            1: resp[1] = 1'b0;
            2: resp[3] = ~resp[3];
            3: resp[0] = 1'b0;
            4: resp[2] = 1'b0;
            default: ;
        endcase
        resp4    = ref_block({a4, b4, c4, d4, e4});
        resp4[3] = ~resp4[3];
    end
    assign {out_and, out_or, out_not, out_complex}     = resp;
    assign {out_and4, out_or4, out_not4, out_complex4} = resp4;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start on dut and count cycles until done (bounded).
    task automatic run_sweep(output int cycles);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        while (!done && cycles < BUDGET) begin
            @(posedge clk);
            #1 cycles++;
        end
    endtask

    typedef struct {
        string      name;
        int         mode;
        int         err;
        logic       pass;
        logic       fev;
        logic [4:0] fvec;
        logic [4:0] last;
        int         cycles;
    } sweep_vec_t;

    sweep_vec_t tbl[5];

    initial begin
        int cyc;
        int rst_mode;

`ifdef SIMPLE_ASSIGN_CHK_STOP_ON_ERR_EN
        tbl[0] = '{"golden",    0,  0, 1'b1, 1'b0, 5'd0, 5'd31, 96};
        tbl[1] = '{"not_stuck0",1,  1, 1'b0, 1'b1, 5'd0, 5'd0,  3};
        tbl[2] = '{"and_inv",   2,  1, 1'b0, 1'b1, 5'd0, 5'd0,  3};
        tbl[3] = '{"cplx_stuck0",3, 1, 1'b0, 1'b1, 5'd7, 5'd7,  24};
        tbl[4] = '{"or_stuck0", 4,  1, 1'b0, 1'b1, 5'd2, 5'd2,  9};
        rst_mode = 0;
`else
        tbl[0] = '{"golden",    0,  0, 1'b1, 1'b0, 5'd0, 5'd31, 96};
        tbl[1] = '{"not_stuck0",1, 24, 1'b0, 1'b1, 5'd0, 5'd31, 96};
        tbl[2] = '{"and_inv",   2, 32, 1'b0, 1'b1, 5'd0, 5'd31, 96};
        tbl[3] = '{"cplx_stuck0",3,11, 1'b0, 1'b1, 5'd7, 5'd31, 96};
        tbl[4] = '{"or_stuck0", 4, 30, 1'b0, 1'b1, 5'd2, 5'd31, 96};
        rst_mode = 3;
`endif

        rst = 1'b1; start = 1'b0; start4 = 1'b0; mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_pass",  32'(pass), 0);
        check("rst_err",   32'(err_count), 0);
        check("rst_fev",   32'(first_err_valid), 0);
        check("rst_fvec",  32'(first_err_vec), 0);
        check("rst_abcde", 32'({a, b, c, d, e}), 0);
        @(negedge clk) rst = 1'b0;

        // --- table-driven full sweeps -------------------------------------
        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            run_sweep(cyc);
            check({tbl[i].name, "_cycles"}, 32'(cyc), 32'(tbl[i].cycles));
            check({tbl[i].name, "_done"},   32'(done), 1);
            check({tbl[i].name, "_busy"},   32'(busy), 0);
            check({tbl[i].name, "_pass"},   32'(pass), 32'(tbl[i].pass));
            check({tbl[i].name, "_err"},    32'(err_count), 32'(tbl[i].err));
            check({tbl[i].name, "_fev"},    32'(first_err_valid), 32'(tbl[i].fev));
            check({tbl[i].name, "_fvec"},   32'(first_err_vec), 32'(tbl[i].fvec));
            check({tbl[i].name, "_abcde"},  32'({a, b, c, d, e}), 32'(tbl[i].last));
        end

        // --- restart from DONE clears the previous (failing) results ------
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("restart_done",  32'(done), 0);
        check("restart_busy",  32'(busy), 1);
        check("restart_err",   32'(err_count), 0);
        check("restart_fev",   32'(first_err_valid), 0);
        check("restart_pass",  32'(pass), 0);
        check("restart_abcde", 32'({a, b, c, d, e}), 0);
        // start pulsed mid-sweep must not disturb timing
        cyc = 0;
        while (!done && cyc < BUDGET) begin
            start = (cyc == 20);
            @(posedge clk);
            #1 cyc++;
        end
        start = 1'b0;
        check("busy_start_cycles", 32'(cyc), 96);
        check("busy_start_pass",   32'(pass), 1);

        // --- reset in the middle of a sweep --------------------------------
        mode = rst_mode;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while ({a, b, c, d, e} != 5'd10 && cyc < BUDGET) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("reach_vec10", 32'({a, b, c, d, e}), 10);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy",  32'(busy), 0);
        check("midrst_done",  32'(done), 0);
        check("midrst_pass",  32'(pass), 0);
        check("midrst_err",   32'(err_count), 0);
        check("midrst_fev",   32'(first_err_valid), 0);
        check("midrst_fvec",  32'(first_err_vec), 0);
        check("midrst_abcde", 32'({a, b, c, d, e}), 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("idle_stays", 32'(busy), 0);
        mode = 0;
        run_sweep(cyc);
        check("post_rst_cycles", 32'(cyc), 96);
        check("post_rst_pass",   32'(pass), 1);
        check("post_rst_err",    32'(err_count), 0);

        // --- ERR_W=4, no settle, out_and inverted --------------------------
        @(negedge clk) start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        cyc = 0;
        while (!done4 && cyc < BUDGET) begin
            @(posedge clk);
            #1 cyc++;
        end
`ifdef SIMPLE_ASSIGN_CHK_STOP_ON_ERR_EN
        check("w4_cycles", 32'(cyc), 2);
        check("w4_err",    32'(err_count4), 1);
`else
        check("w4_cycles", 32'(cyc), 64);
        check("w4_err",    32'(err_count4), 15);
`endif
        check("w4_pass",  32'(pass4), 0);
        check("w4_fev",   32'(first_err_valid4), 1);
        check("w4_fvec",  32'(first_err_vec4), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
